// File: rtl/ram_arb_pkg.sv
// Shared state encoding, widths and ring helper for ram_port_arbiter.
package ram_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } arb_state_e;

  // Beat counter holds 0..lock_max-1 with lock_max up to 15.
  localparam int BEAT_W = 4;
  // Requester index covers up to 8 requesters.
  localparam int IDX_W  = 3;

  // Successor of idx in a ring of n requesters.
  function automatic logic [IDX_W-1:0] ring_next(input logic [IDX_W-1:0] idx, input int n);
    logic [IDX_W-1:0] last_v;
    last_v = IDX_W'(n - 1);
    return (idx == last_v) ? {IDX_W{1'b0}} : idx + {{(IDX_W-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/ram_port_arbiter_if.sv
// Requester-side bus of ram_port_arbiter: packed per-requester slices plus shared read data.
interface ram_port_arbiter_if #(
  parameter int data_width    = 8,
  parameter int address_width = 4,
  parameter int num_req       = 2
);

  logic [num_req-1:0]               req;
  logic [num_req-1:0]               we;
  logic [num_req*address_width-1:0] addr;
  logic [num_req*data_width-1:0]    wdata;
  logic [num_req-1:0]               lock;
  logic [num_req-1:0]               gnt;
  logic [num_req-1:0]               rvalid;
  logic [data_width-1:0]            rdata;

  modport master (
    output req, we, addr, wdata, lock,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, addr, wdata, lock,
    output gnt, rvalid, rdata
  );

endinterface

// File: rtl/ram_port_arbiter_rr_picker.sv
// rr_picker: combinational round-robin pick starting at ptr; reports one-hot winner and its index.
module rr_picker
  import ram_arb_pkg::*;
#(
  parameter int num_req = 2
) (
  input  logic [num_req-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic               found,
  output logic [IDX_W-1:0]   idx,
  output logic [num_req-1:0] onehot
);

  logic [IDX_W-1:0] hi_idx_s;
  logic [IDX_W-1:0] lo_idx_s;
  logic             hi_found_s;
  logic             take_hi_s;

  // Lowest requester at or above ptr wins; if none, wrap to the lowest requester overall.
  always_comb begin
    hi_idx_s   = {IDX_W{1'b0}};
    lo_idx_s   = {IDX_W{1'b0}};
    hi_found_s = 1'b0;
    take_hi_s  = 1'b0;
    found      = 1'b0;
    onehot     = '0;
    for (int j = num_req - 1; j >= 0; j--) begin
      take_hi_s  = req[j] && (j >= int'(ptr));
      lo_idx_s   = req[j] ? IDX_W'(j) : lo_idx_s;
      hi_idx_s   = take_hi_s ? IDX_W'(j) : hi_idx_s;
      hi_found_s = hi_found_s | take_hi_s;
      found      = found | req[j];
    end
    idx = hi_found_s ? hi_idx_s : lo_idx_s;
    for (int j = 0; j < num_req; j++) begin
      onehot[j] = found && (idx == IDX_W'(j));
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: round-robin IDLE/XFER arbiter sharing one RAM among num_req requesters.
// Define RAM_ARB_LOCK_EN to let a locked winner keep the RAM for up to lock_max back-to-back beats.
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int data_width    = 8,
  parameter int address_width = 4,
  parameter int num_req       = 2,
  parameter int lock_max      = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  ram_port_arbiter_if.slave        bus,
  output logic                     ram_wr_en,
  output logic                     ram_rd_en,
  output logic [address_width-1:0] ram_wr_addr,
  output logic [address_width-1:0] ram_rd_addr,
  output logic [data_width-1:0]    ram_data_in,
  input  logic [data_width-1:0]    ram_data_out
);

  arb_state_e               state_r;
  logic [IDX_W-1:0]         ptr_r;
  logic [IDX_W-1:0]         winner_r;
  logic [num_req-1:0]       gnt_r;
  logic [num_req-1:0]       rvalid_r;

  logic                     pick_found_s;
  logic [IDX_W-1:0]         pick_idx_s;
  logic [num_req-1:0]       pick_onehot_s;

  logic                     win_we_s;
  logic [address_width-1:0] win_addr_s;
  logic [data_width-1:0]    win_wdata_s;
  logic                     hold_s;

  rr_picker #(
    .num_req (num_req)
  ) u_picker (
    .req    (bus.req),
    .ptr    (ptr_r),
    .found  (pick_found_s),
    .idx    (pick_idx_s),
    .onehot (pick_onehot_s)
  );

  // Route the granted requester's live slices to the RAM; a locked burst picks up each new beat here.
  always_comb begin
    win_we_s    = 1'b0;
    win_addr_s  = '0;
    win_wdata_s = '0;
    for (int i = 0; i < num_req; i++) begin
      win_we_s    = win_we_s | (gnt_r[i] & bus.we[i]);
      win_addr_s  = win_addr_s | (bus.addr[i*address_width +: address_width] & {address_width{gnt_r[i]}});
      win_wdata_s = win_wdata_s | (bus.wdata[i*data_width +: data_width] & {data_width{gnt_r[i]}});
    end
  end

`ifdef RAM_ARB_LOCK_EN
  logic [BEAT_W-1:0] beat_r;
  logic              win_lock_s;
  logic              win_req_s;

  assign win_lock_s = |(gnt_r & bus.lock);
  assign win_req_s  = |(gnt_r & bus.req);
  assign hold_s     = win_lock_s & win_req_s & (beat_r < BEAT_W'(lock_max - 1));

  // Beat counter: advances on each extended beat and clears whenever the burst ends.
  always_ff @(posedge clk) begin
    if (rst) begin
      beat_r <= {BEAT_W{1'b0}};
    end else if (state_r == XFER && hold_s) begin
      beat_r <= beat_r + BEAT_W'(1'b1);
    end else begin
      beat_r <= {BEAT_W{1'b0}};
    end
  end
`else
  logic unused_lock_s;
  assign unused_lock_s = ^{bus.lock, 32'(lock_max)};
  assign hold_s        = 1'b0;
`endif

  // Arbitration FSM; gnt and rvalid are registered alongside the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= IDLE;
      ptr_r    <= {IDX_W{1'b0}};
      winner_r <= {IDX_W{1'b0}};
      gnt_r    <= '0;
      rvalid_r <= '0;
    end else begin
      rvalid_r <= (state_r == XFER && !win_we_s) ? gnt_r : '0;
      case (state_r)
        IDLE: begin
          if (pick_found_s) begin
            state_r  <= XFER;
            winner_r <= pick_idx_s;
            gnt_r    <= pick_onehot_s;
          end else begin
            gnt_r    <= '0;
          end
        end
        XFER: begin
          if (hold_s) begin
            gnt_r    <= gnt_r;
          end else begin
            state_r  <= IDLE;
            ptr_r    <= ring_next(winner_r, num_req);
            gnt_r    <= '0;
          end
        end
        default: begin
          state_r <= IDLE;
          gnt_r   <= '0;
        end
      endcase
    end
  end

  assign bus.gnt     = gnt_r;
  assign bus.rvalid  = rvalid_r;
  assign bus.rdata   = ram_data_out;

  assign ram_wr_en   = (state_r == XFER) & win_we_s;
  assign ram_rd_en   = (state_r == XFER) & ~win_we_s;
  assign ram_wr_addr = win_addr_s;
  assign ram_rd_addr = win_addr_s;
  assign ram_data_in = win_wdata_s;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter with 2 requesters, 8-bit data, 4-bit addresses.
// Burst expectations switch on RAM_ARB_LOCK_EN.
module tb_ram_port_arbiter;

  localparam int DW = 8;
  localparam int AW = 4;
  localparam int NR = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          ram_wr_en;
  logic          ram_rd_en;
  logic [AW-1:0] ram_wr_addr;
  logic [AW-1:0] ram_rd_addr;
  logic [DW-1:0] ram_data_in;
  logic [DW-1:0] ram_data_out;
  logic [DW-1:0] mem [16];

  int tests = 0;
  int fails = 0;

  ram_port_arbiter_if #(.data_width(DW), .address_width(AW), .num_req(NR)) bus ();

  ram_port_arbiter #(
    .data_width    (DW),
    .address_width (AW),
    .num_req       (NR),
    .lock_max      (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .ram_wr_en    (ram_wr_en),
    .ram_rd_en    (ram_rd_en),
    .ram_wr_addr  (ram_wr_addr),
    .ram_rd_addr  (ram_rd_addr),
    .ram_data_in  (ram_data_in),
    .ram_data_out (ram_data_out)
  );

  always #5 clk = ~clk;

  // RAM with a registered read port.
  always @(posedge clk) begin
    if (ram_wr_en) mem[ram_wr_addr] <= ram_data_in;
    if (ram_rd_en) ram_data_out <= mem[ram_rd_addr];
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic drive(input logic [1:0] r, input logic [1:0] w, input logic [1:0] lk,
                       input logic [3:0] a0, input logic [3:0] a1,
                       input logic [7:0] d0, input logic [7:0] d1);
    bus.req   = r;
    bus.we    = w;
    bus.lock  = lk;
    bus.addr  = {a1, a0};
    bus.wdata = {d1, d0};
  endtask

  initial begin
    logic [15:0] g_tab;
    logic [15:0] rv_tab;
    logic [13:0] lg_tab;
    logic [27:0] la_tab;
    logic [3:0]  beat0;

    // Reset values
    rst = 1'b1;
    drive(2'b00, 2'b00, 2'b00, 4'd0, 4'd0, 8'h00, 8'h00);
    step();
    step();
    sample();
    check_eq("rst_gnt",    32'(bus.gnt),    32'd0);
    check_eq("rst_rvalid", 32'(bus.rvalid), 32'd0);
    check_eq("rst_wr_en",  32'(ram_wr_en),  32'd0);
    check_eq("rst_rd_en",  32'(ram_rd_en),  32'd0);

    // Requester 0 writes A5 to address 3; grant lands in the 2nd cycle
    step();
    rst = 1'b0;
    drive(2'b01, 2'b01, 2'b00, 4'd3, 4'd0, 8'hA5, 8'h00);
    sample();
    check_eq("wr_c1_gnt", 32'(bus.gnt), 32'd0);
    check_eq("wr_c1_wr_en", 32'(ram_wr_en), 32'd0);
    step();
    sample();
    check_eq("wr_c2_gnt",     32'(bus.gnt),     32'h1);
    check_eq("wr_c2_wr_en",   32'(ram_wr_en),   32'd1);
    check_eq("wr_c2_rd_en",   32'(ram_rd_en),   32'd0);
    check_eq("wr_c2_wr_addr", 32'(ram_wr_addr), 32'd3);
    check_eq("wr_c2_data_in", 32'(ram_data_in), 32'hA5);

    // Requester 1 reads address 3 back
    step();
    drive(2'b10, 2'b00, 2'b00, 4'd0, 4'd3, 8'h00, 8'h00);
    sample();
    check_eq("rd_c1_gnt",   32'(bus.gnt),   32'd0);
    check_eq("rd_c1_wr_en", 32'(ram_wr_en), 32'd0);
    step();
    sample();
    check_eq("rd_c2_gnt",     32'(bus.gnt),     32'h2);
    check_eq("rd_c2_rd_en",   32'(ram_rd_en),   32'd1);
    check_eq("rd_c2_wr_en",   32'(ram_wr_en),   32'd0);
    check_eq("rd_c2_rd_addr", 32'(ram_rd_addr), 32'd3);
    step();
    drive(2'b00, 2'b00, 2'b00, 4'd0, 4'd0, 8'h00, 8'h00);
    sample();
    check_eq("rd_c3_rvalid", 32'(bus.rvalid), 32'h2);
    check_eq("rd_c3_rdata",  32'(bus.rdata),  32'hA5);
    check_eq("rd_c3_gnt",    32'(bus.gnt),    32'd0);

    // Both requesters read continuously from reset: 0,1,0,1 on cycles 2,4,6,8
    step();
    rst = 1'b1;
    drive(2'b11, 2'b00, 2'b00, 4'd5, 4'd6, 8'h00, 8'h00);
    step();
    step();
    rst = 1'b0;
    g_tab  = 16'b1000_0100_1000_0100;
    rv_tab = 16'b0001_0010_0001_0000;
    for (int c = 0; c < 8; c++) begin
      sample();
      check_eq($sformatf("rr_gnt_c%0d", c + 1),    32'(bus.gnt),    32'(g_tab[2*c +: 2]));
      check_eq($sformatf("rr_rd_en_c%0d", c + 1),  32'(ram_rd_en),  32'(|g_tab[2*c +: 2]));
      check_eq($sformatf("rr_rvalid_c%0d", c + 1), 32'(bus.rvalid), 32'(rv_tab[2*c +: 2]));
      step();
    end

    // Cycle 9 idle, cycle 10 read XFER aborted by reset
    sample();
    check_eq("rr_gnt_c9",    32'(bus.gnt),    32'd0);
    check_eq("rr_rvalid_c9", 32'(bus.rvalid), 32'h2);
    step();
    rst = 1'b1;
    sample();
    check_eq("abort_xfer_gnt", 32'(bus.gnt),   32'h1);
    check_eq("abort_xfer_rd",  32'(ram_rd_en), 32'd1);
    step();
    rst = 1'b0;
    sample();
    check_eq("abort_gnt",    32'(bus.gnt),    32'd0);
    check_eq("abort_rvalid", 32'(bus.rvalid), 32'd0);
    check_eq("abort_wr_en",  32'(ram_wr_en),  32'd0);
    check_eq("abort_rd_en",  32'(ram_rd_en),  32'd0);
    step();
    sample();
    check_eq("abort_next_gnt", 32'(bus.gnt), 32'h1);

    // Requester 0 writes with lock held, requester 1 also requesting
    step();
    rst = 1'b1;
    drive(2'b11, 2'b11, 2'b01, 4'd0, 4'd9, 8'h10, 8'h99);
    step();
    step();
    rst = 1'b0;
    beat0 = 4'd0;
`ifdef RAM_ARB_LOCK_EN
    lg_tab = 14'b10_00_01_01_01_01_00;
    la_tab = 28'h9032100;
`else
    lg_tab = 14'b00_01_00_10_00_01_00;
    la_tab = 28'h0109000;
`endif
    for (int c = 0; c < 7; c++) begin
      bus.addr  = {4'd9, beat0};
      bus.wdata = {8'h99, 8'h10 + {4'h0, beat0}};
      sample();
      check_eq($sformatf("lk_gnt_c%0d", c + 1),   32'(bus.gnt),   32'(lg_tab[2*c +: 2]));
      check_eq($sformatf("lk_wr_en_c%0d", c + 1), 32'(ram_wr_en), 32'(|lg_tab[2*c +: 2]));
      if (|lg_tab[2*c +: 2]) begin
        check_eq($sformatf("lk_wr_addr_c%0d", c + 1), 32'(ram_wr_addr), 32'(la_tab[4*c +: 4]));
      end
      if (bus.gnt[0]) beat0 = beat0 + 4'd1;
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
